// File: rtl/mult_matrix_seq_pkg.sv
// Shared types and sizing helpers for the matrix job sequencer.
// N_RD shrinks to SIZE when MATRIX_SEQ_SKEW_EN is defined (block skews raw rows itself).
package mult_matrix_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_t;

  function automatic int n_feed(input int size);
    return 2 * size - 1;
  endfunction

  function automatic int n_rd(input int size);
`ifdef MATRIX_SEQ_SKEW_EN
    return size;
`else
    return n_feed(size);
`endif
  endfunction

  // Job cycle counter must reach the done cycle, 3 + lat + size.
  function automatic int cnt_w(input int size, input int lat);
    return $clog2(lat + size + 4);
  endfunction

endpackage

// File: rtl/matrix_skew_line.sv
// Diagonal skew: column c of the row is delayed c cycles, zero-filled from reset.
// Column 0 is combinational pass-through; no backpressure.
module matrix_skew_line #(
  parameter int DATA_SIZE = 4,
  parameter int SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_SIZE*SIZE-1:0] row_in,
  output logic [DATA_SIZE*SIZE-1:0] row_out
);

  for (genvar c = 0; c < SIZE; c++) begin : g_col
    localparam int HI = (SIZE - c) * DATA_SIZE - 1;
    if (c == 0) begin : g_pass
      assign row_out[HI -: DATA_SIZE] = row_in[HI -: DATA_SIZE];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < c; s++) sr[s] <= '0;
        end else begin
          sr[0] <= row_in[HI -: DATA_SIZE];
          for (int s = 1; s < c; s++) sr[s] <= sr[s-1];
        end
      end
      assign row_out[HI -: DATA_SIZE] = sr[c-1];
    end
  end

endmodule

// File: rtl/mult_matrix_seq.sv
// Matrix job sequencer: reads a job from row memory, streams it, flags out_valid, pulses done.
// Row k leaves 3+k cycles after start; no backpressure. Optional MATRIX_SEQ_SKEW_EN skews raw rows.
module mult_matrix_seq
  import mult_matrix_seq_pkg::*;
#(
  parameter int DATA_SIZE  = 4,
  parameter int SIZE       = 3,
  parameter int ADDR_W     = 8,
  parameter int REVERT_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_SIZE*SIZE-1:0] rd_data,
  output logic [DATA_SIZE*SIZE-1:0] input_stream,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int W  = DATA_SIZE * SIZE;
  localparam int NF = n_feed(SIZE);
  localparam int NR = n_rd(SIZE);
  localparam int CW = cnt_w(SIZE, REVERT_LAT);
  localparam int RW = $clog2(NR + 1);

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_ST_FIRST = CW'(3);
  localparam logic [CW-1:0] C_ST_LAST  = CW'(2 + NF);
  localparam logic [CW-1:0] C_OV_FIRST = CW'(3 + REVERT_LAT);
  localparam logic [CW-1:0] C_OV_LAST  = CW'(2 + REVERT_LAT + SIZE);
  localparam logic [CW-1:0] C_PRE_DONE = CW'(2 + REVERT_LAT + SIZE);
  localparam logic [RW-1:0] C_NR       = RW'(NR);

  state_t          state, state_nxt;
  logic [CW-1:0]   cyc, cyc_nxt;
  logic [RW-1:0]   rd_idx;
  logic [W-1:0]    stream_src;
  logic            stream_ld;

  // cyc is the cycle number relative to the accepted start edge; 0 while idle.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    case (state)
      IDLE: if (start) begin
        state_nxt = FEED;
        cyc_nxt   = C_ONE;
      end
      FEED: begin
        cyc_nxt = cyc + C_ONE;
        if (cyc == C_PRE_DONE)     state_nxt = DONE;
        else if (cyc == C_ST_LAST) state_nxt = FLUSH;
      end
      FLUSH: begin
        cyc_nxt = cyc + C_ONE;
        if (cyc == C_PRE_DONE) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
    end
  end

  // rd_idx counts reads issued so far, including the one on the bus now.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_idx  <= '0;
    end else if (state == IDLE && start) begin
      rd_en   <= 1'b1;
      rd_addr <= base_addr;
      rd_idx  <= RW'(1);
    end else if (rd_en) begin
      if (rd_idx == C_NR) begin
        rd_en <= 1'b0;
      end else begin
        rd_addr <= rd_addr + 1'b1;
        rd_idx  <= rd_idx + RW'(1);
      end
    end
  end

`ifdef MATRIX_SEQ_SKEW_EN
  logic         rd_vld;
  logic [W-1:0] skew_in;

  always_ff @(posedge clk) begin
    if (rst) rd_vld <= 1'b0;
    else     rd_vld <= rd_en;
  end

  // Only real read data enters the skew line, so trailing diagonals fill with zeros.
  assign skew_in = rd_vld ? rd_data : '0;

  matrix_skew_line #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE      (SIZE)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .row_in  (skew_in),
    .row_out (stream_src)
  );
`else
  assign stream_src = rd_data;
`endif

  assign stream_ld = (cyc_nxt >= C_ST_FIRST) && (cyc_nxt <= C_ST_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      input_stream <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      input_stream <= stream_ld ? stream_src : '0;
      out_valid    <= (cyc_nxt >= C_OV_FIRST) && (cyc_nxt <= C_OV_LAST);
      busy         <= (state_nxt != IDLE);
      done         <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mult_matrix_seq.sv
// Bench for mult_matrix_seq: timeline model checked every cycle plus directed literal checks.
module tb_mult_matrix_seq;

  localparam int DW  = 4;
  localparam int SZ  = 3;
  localparam int AW  = 8;
  localparam int LAT = 3;
  localparam int W   = DW * SZ;
  localparam int NF  = 2 * SZ - 1;
`ifdef MATRIX_SEQ_SKEW_EN
  localparam int NR  = SZ;
`else
  localparam int NR  = NF;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  input_stream;
  logic          out_valid;
  logic          busy;
  logic          done;

  mult_matrix_seq #(
    .DATA_SIZE  (DW),
    .SIZE       (SZ),
    .ADDR_W     (AW),
    .REVERT_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .input_stream (input_stream),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    else n_pass++;
  endtask

  // Timeline model: a job is just its start cycle and base address.
  int            cyc = 0;
  bit            m_ok = 0;
  bit            m_act = 0;
  int            m_t = 0;
  logic [AW-1:0] m_base = '0;
  logic          e_rd_en, e_ov, e_busy, e_done;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0]  e_stream;

  function automatic logic [W-1:0] row_of(input int k);
    logic [W-1:0]  r;
    logic [W-1:0]  raw;
    logic [AW-1:0] a;
    r = '0;
`ifdef MATRIX_SEQ_SKEW_EN
    for (int c = 0; c < SZ; c++) begin
      if (k - c >= 0 && k - c < SZ) begin
        a = m_base + AW'(k - c);
        raw = mem[a];
        r[(SZ-c)*DW-1 -: DW] = raw[(SZ-c)*DW-1 -: DW];
      end
    end
`else
    a = m_base + AW'(k);
    raw = mem[a];
    r = raw;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    int rel;
    if (rst) begin
      m_ok  = 1;
      m_act = 0;
    end else if (!m_act && start) begin
      m_act  = 1;
      m_t    = cyc;
      m_base = base_addr;
    end
    cyc = cyc + 1;
    rel = cyc - m_t;
    if (m_act && rel > 3 + LAT + SZ) m_act = 0;
    e_busy   = m_act;
    e_rd_en  = m_act && rel >= 1 && rel <= NR;
    if (rst) e_addr = '0;
    else if (e_rd_en) e_addr = m_base + AW'(rel - 1);
    e_stream = (m_act && rel >= 3 && rel < 3 + NF) ? row_of(rel - 3) : '0;
    e_ov     = m_act && rel >= 3 + LAT && rel <= 2 + LAT + SZ;
    e_done   = m_act && rel == 3 + LAT + SZ;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("m_rd_en", 32'(rd_en), 32'(e_rd_en));
      check("m_rd_addr", 32'(rd_addr), 32'(e_addr));
      check("m_stream", 32'(input_stream), 32'(e_stream));
      check("m_out_valid", 32'(out_valid), 32'(e_ov));
      check("m_busy", 32'(busy), 32'(e_busy));
      check("m_done", 32'(done), 32'(e_done));
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_at(input int n);
    goto(n);
    @(negedge clk);
  endtask

  logic [W-1:0]  exp_rows [5];
  logic [AW-1:0] wrap_tab [5];

  initial begin
    int t;
    int t2;
`ifdef MATRIX_SEQ_SKEW_EN
    exp_rows = '{12'h100, 12'h420, 12'h753, 12'h086, 12'h009};
`else
    exp_rows = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
`endif
    wrap_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    for (int i = 0; i < 256; i++) mem[i] = W'(i * 37 + 5);
    mem[8'h10] = 12'h123; mem[8'h11] = 12'h456; mem[8'h12] = 12'h789;
    mem[8'h13] = 12'hABC; mem[8'h14] = 12'hDEF;

    rst = 1'b1; start = 1'b0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_stream", 32'(input_stream), 0);

    // Job 1 with ignored start pulses mid-job and at done.
    t = cyc; base_addr = 8'h10; start = 1'b1;
    goto(t + 1); start = 1'b0;
    @(negedge clk);
    check("j1_rd_en", 32'(rd_en), 1);
    check("j1_addr0", 32'(rd_addr), 32'h10);
    chk_at(t + 3); check("j1_row0", 32'(input_stream), 32'(exp_rows[0]));
    goto(t + 4); base_addr = 8'h55; start = 1'b1;
    goto(t + 5); start = 1'b0; base_addr = 8'h10;
    @(negedge clk); check("j1_ov_pre", 32'(out_valid), 0);
    chk_at(t + 6); check("j1_ov_first", 32'(out_valid), 1);
    chk_at(t + 7); check("j1_row4", 32'(input_stream), 32'(exp_rows[4]));
    chk_at(t + 8); check("j1_flush", 32'(input_stream), 0);
    check("j1_ov_last", 32'(out_valid), 1);
    goto(t + 9); start = 1'b1;
    @(negedge clk); check("j1_done", 32'(done), 1);
    goto(t + 10);
    @(negedge clk); check("j1_busy_fall", 32'(busy), 0);
    t2 = t + 10;
    goto(t2 + 1); start = 1'b0;
    chk_at(t2 + 3); check("j2_row0", 32'(input_stream), 32'(exp_rows[0]));
    chk_at(t2 + 9); check("j2_done", 32'(done), 1);
    goto(t2 + 12);

    // Address wrap.
    t = cyc; base_addr = 8'hFE; start = 1'b1;
    goto(t + 1); start = 1'b0;
    for (int i = 0; i < NR; i++) begin
      chk_at(t + 1 + i);
      check("wrap_addr", 32'(rd_addr), 32'(wrap_tab[i]));
    end
    goto(t + 14);

    // Reset in the middle of a job, then a clean job.
    t = cyc; base_addr = 8'h10; start = 1'b1;
    goto(t + 1); start = 1'b0;
    goto(t + 5); rst = 1'b1;
    goto(t + 6); rst = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 0);
    check("mr_addr", 32'(rd_addr), 0);
    check("mr_stream", 32'(input_stream), 0);
    check("mr_ov", 32'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      chk_at(t + 7 + i);
      check("mr_no_done", 32'(done), 0);
    end
    t = cyc; start = 1'b1;
    goto(t + 1); start = 1'b0;
    chk_at(t + 3); check("mr_row0", 32'(input_stream), 32'(exp_rows[0]));
    chk_at(t + 9); check("mr_done", 32'(done), 1);
    goto(t + 12);

    // Reset and start together: reset wins.
    t = cyc; rst = 1'b1; start = 1'b1;
    goto(t + 1); rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_at(t + 1 + i);
      check("rs_busy", 32'(busy), 0);
      check("rs_rd_en", 32'(rd_en), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
